// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port word memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-port priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 22
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [31:0]           i_rdata_o,
  input  logic                  d_req_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [3:0]            d_wmask_i,
  input  logic [31:0]           d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [31:0]           d_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rstrb_o,
  output logic [3:0]            mem_wmask_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  logic   gnt_i, gnt_d;
  logic   d_is_write;
  logic   rd_pend_q, rd_pend_d;
  owner_e rd_owner_q, rd_owner_d;

  assign d_is_write = |d_wmask_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when the data port won the most recent grant; reset means "fetch last".
  logic last_data_q, last_data_d;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (rst_ni) begin
      if (i_req_i && d_req_i) begin
        gnt_i = last_data_q;
        gnt_d = ~last_data_q;
      end else begin
        gnt_i = i_req_i;
        gnt_d = d_req_i;
      end
    end
    last_data_d = last_data_q;
    if (gnt_i || gnt_d) last_data_d = gnt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_data_q <= 1'b0;
    else         last_data_q <= last_data_d;
  end
`else
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (rst_ni) begin
      gnt_d = d_req_i;
      gnt_i = i_req_i & ~d_req_i;
    end
  end
`endif

  // Memory-side request mux: all zeros when nothing is granted.
  always_comb begin
    mem_addr_o  = '0;
    mem_rstrb_o = 1'b0;
    mem_wmask_o = 4'b0000;
    mem_wdata_o = 32'h0;
    if (gnt_d) begin
      mem_addr_o = d_addr_i;
      if (d_is_write) begin
        mem_wmask_o = d_wmask_i;
        mem_wdata_o = d_wdata_i;
      end else begin
        mem_rstrb_o = 1'b1;
      end
    end else if (gnt_i) begin
      mem_addr_o  = i_addr_i;
      mem_rstrb_o = 1'b1;
    end
  end

  always_comb begin
    rd_pend_d  = gnt_i | (gnt_d & ~d_is_write);
    rd_owner_d = gnt_d ? OWNER_DATA : OWNER_FETCH;
  end

  // Reset clears the tracker asynchronously, so an in-flight read is dropped at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWNER_FETCH;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign i_gnt_o    = gnt_i;
  assign d_gnt_o    = gnt_d;
  assign i_rvalid_o = rd_pend_q & (rd_owner_q == OWNER_FETCH);
  assign d_rvalid_o = rd_pend_q & (rd_owner_q == OWNER_DATA);
  assign i_rdata_o  = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, reset-in-flight sequence and random traffic vs. a reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 22;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_wmask;
  logic [31:0]   d_wdata;
  logic          i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o;
  logic [31:0]   i_rdata_o, d_rdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rstrb_o;
  logic [3:0]    mem_wmask_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata;
  logic          init_req;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_wmask_i(d_wmask), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_rstrb_o(mem_rstrb_o), .mem_wmask_o(mem_wmask_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] init_val(int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'hAAAAAAAA;
    return 32'hC0DE0000 | 32'(i << 2);
  endfunction

  // Memory with registered read, indexed by word address bits [9:2]
  logic [31:0] tbmem [0:255];
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) tbmem[i] <= init_val(i);
    end else begin
      if (mem_rstrb_o) mem_rdata <= tbmem[mem_addr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask_o[b]) tbmem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(bit ir, logic [AW-1:0] ia, bit dr, logic [AW-1:0] da,
                       logic [3:0] wm, logic [31:0] wd);
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wmask = wm; d_wdata = wd;
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_igt"}, 32'(i_gnt_o), 32'd0);
    chk({tag, "_dgt"}, 32'(d_gnt_o), 32'd0);
    chk({tag, "_iv"}, 32'(i_rvalid_o), 32'd0);
    chk({tag, "_dv"}, 32'(d_rvalid_o), 32'd0);
    chk({tag, "_strb"}, 32'(mem_rstrb_o), 32'd0);
    chk({tag, "_mask"}, 32'(mem_wmask_o), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
    chk({tag, "_wd"}, mem_wdata_o, 32'd0);
  endtask

  // Directed vectors
  typedef struct {
    bit ir; logic [AW-1:0] ia; bit dr; logic [AW-1:0] da; logic [3:0] wm; logic [31:0] wd;
    bit eig; bit edg; bit eiv; bit edv; logic [31:0] erd;
    bit estrb; logic [3:0] emask; logic [AW-1:0] eaddr; logic [31:0] ewd;
  } vec_t;

  function automatic vec_t mkv(bit ir, logic [AW-1:0] ia, bit dr, logic [AW-1:0] da,
                               logic [3:0] wm, logic [31:0] wd, bit eig, bit edg,
                               bit eiv, bit edv, logic [31:0] erd, bit estrb,
                               logic [3:0] emask, logic [AW-1:0] eaddr, logic [31:0] ewd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.wm = wm; v.wd = wd;
    v.eig = eig; v.edg = edg; v.eiv = eiv; v.edv = edv; v.erd = erd;
    v.estrb = estrb; v.emask = emask; v.eaddr = eaddr; v.ewd = ewd;
    return v;
  endfunction

  // Reference model state
  typedef struct { bit owner_data; logic [31:0] data; } rsp_t;
  rsp_t        pendq [$];
  logic [31:0] sh [0:255];
  bit          m_last_data;

  task automatic model_reset();
    pendq.delete();
    m_last_data = 1'b0;
    for (int i = 0; i < 256; i++) sh[i] = init_val(i);
  endtask

  task automatic model_step(bit ir, logic [AW-1:0] ia, bit dr, logic [AW-1:0] da,
                            logic [3:0] wm, logic [31:0] wd);
    bit gi, gd, eiv, edv;
    logic [31:0] erd;
    rsp_t r;
    drive(ir, ia, dr, da, wm, wd);
    if (ir && dr) gd = RR ? !m_last_data : 1'b1;
    else          gd = dr;
    gi = ir && !gd;
    eiv = 1'b0; edv = 1'b0; erd = 32'h0;
    if (pendq.size() > 0) begin
      r = pendq.pop_front();
      eiv = !r.owner_data; edv = r.owner_data; erd = r.data;
    end
    chk("m_igt", 32'(i_gnt_o), 32'(gi));
    chk("m_dgt", 32'(d_gnt_o), 32'(gd));
    chk("m_iv", 32'(i_rvalid_o), 32'(eiv));
    chk("m_dv", 32'(d_rvalid_o), 32'(edv));
    if (eiv) chk("m_irdata", i_rdata_o, erd);
    if (edv) chk("m_drdata", d_rdata_o, erd);
    chk("m_addr", 32'(mem_addr_o), gd ? 32'(da) : (gi ? 32'(ia) : 32'd0));
    chk("m_strb", 32'(mem_rstrb_o), 32'(gi || (gd && wm == 4'b0)));
    chk("m_mask", 32'(mem_wmask_o), gd ? 32'(wm) : 32'd0);
    chk("m_wd", mem_wdata_o, (gd && wm != 4'b0) ? wd : 32'h0);
    $display("txn rnd ir=%0b dr=%0b wm=%h -> igt=%0b dgt=%0b iv=%0b dv=%0b",
             ir, dr, wm, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o);
    if (gi || gd) m_last_data = gd;
    if (gi) begin
      r.owner_data = 1'b0; r.data = sh[ia[9:2]]; pendq.push_back(r);
    end else if (gd) begin
      if (wm == 4'b0) begin
        r.owner_data = 1'b1; r.data = sh[da[9:2]]; pendq.push_back(r);
      end else begin
        for (int b = 0; b < 4; b++) if (wm[b]) sh[da[9:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  vec_t vt [13];

  initial begin
    vec_t v;
    bit dwin, prev_dwin;
    logic [AW-1:0] ra, rb;
    logic [3:0] rwm;

    rst_n = 1'b0; init_req = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0; d_wmask = 4'b0; d_wdata = 32'h0;

    // Conflict burst first (fresh reset state), then test-plan sequences
    prev_dwin = 1'b0;
    for (int k = 0; k < 6; k++) begin
      dwin = RR ? (k % 2 == 0) : 1'b1;
      vt[k] = mkv(1, 22'h0, 1, 22'h4, 4'h0, 32'h0, !dwin, dwin,
                  (k > 0) && !prev_dwin, (k > 0) && prev_dwin,
                  prev_dwin ? 32'hC0DE0004 : 32'hC0DE0000,
                  1, 4'h0, dwin ? 22'h4 : 22'h0, 32'h0);
      prev_dwin = dwin;
    end
    vt[6]  = mkv(0, 22'h0, 0, 22'h0, 4'h0, 32'h0, 0, 0, !prev_dwin, prev_dwin,
                 prev_dwin ? 32'hC0DE0004 : 32'hC0DE0000, 0, 4'h0, 22'h0, 32'h0);
    vt[7]  = mkv(1, 22'h10, 0, 22'h0, 4'h0, 32'h0, 1, 0, 0, 0, 32'h0, 1, 4'h0, 22'h10, 32'h0);
    vt[8]  = mkv(0, 22'h0, 1, 22'h4, 4'h0, 32'h0, 0, 1, 1, 0, 32'hDEADBEEF, 1, 4'h0, 22'h4, 32'h0);
    vt[9]  = mkv(1, 22'h8, 0, 22'h0, 4'h0, 32'h0, 1, 0, 0, 1, 32'hC0DE0004, 1, 4'h0, 22'h8, 32'h0);
    vt[10] = mkv(0, 22'h0, 1, 22'h20, 4'b0011, 32'h12345678, 0, 1, 1, 0, 32'hC0DE0008,
                 0, 4'b0011, 22'h20, 32'h12345678);
    vt[11] = mkv(0, 22'h0, 1, 22'h20, 4'h0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 4'h0, 22'h20, 32'h0);
    vt[12] = mkv(0, 22'h0, 0, 22'h0, 4'h0, 32'h0, 0, 0, 0, 1, 32'hAAAA5678, 0, 4'h0, 22'h0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_zero("rst0");
    rst_n = 1'b1; init_req = 1'b0;

    for (int k = 0; k < 13; k++) begin
      v = vt[k];
      drive(v.ir, v.ia, v.dr, v.da, v.wm, v.wd);
      chk("tv_igt", 32'(i_gnt_o), 32'(v.eig));
      chk("tv_dgt", 32'(d_gnt_o), 32'(v.edg));
      chk("tv_iv", 32'(i_rvalid_o), 32'(v.eiv));
      chk("tv_dv", 32'(d_rvalid_o), 32'(v.edv));
      if (v.eiv) chk("tv_irdata", i_rdata_o, v.erd);
      if (v.edv) chk("tv_drdata", d_rdata_o, v.erd);
      chk("tv_strb", 32'(mem_rstrb_o), 32'(v.estrb));
      chk("tv_mask", 32'(mem_wmask_o), 32'(v.emask));
      chk("tv_addr", 32'(mem_addr_o), 32'(v.eaddr));
      chk("tv_wd", mem_wdata_o, v.ewd);
      $display("txn vec %0d: igt=%0b dgt=%0b iv=%0b dv=%0b idata=%h ddata=%h",
               k, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, i_rdata_o, d_rdata_o);
    end

    // Reset pulled the cycle after a fetch grant: the read must vanish
    drive(1, 22'h10, 0, 22'h0, 4'h0, 32'h0);
    chk("rs_igt", 32'(i_gnt_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b0; init_req = 1'b1;
    i_req = 1'b1; d_req = 1'b1; d_addr = 22'h4; d_wmask = 4'b0101; d_wdata = 32'hFFFFFFFF;
    #1;
    chk_zero("rs1");
    @(negedge clk); #1;
    init_req = 1'b0;
    chk_zero("rs2");
    @(posedge clk); #2;
    i_req = 1'b0; d_req = 1'b0; d_wmask = 4'b0;
    rst_n = 1'b1;
    chk("rs3_iv", 32'(i_rvalid_o), 32'd0);

    model_reset();
    model_step(1, 22'h10, 1, 22'h4, 4'h0, 32'h0);
    chk("rs_first_dgt", 32'(d_gnt_o), 32'd1);
    chk("rs_first_iv", 32'(i_rvalid_o), 32'd0);

    for (int n = 0; n < 400; n++) begin
      ra  = 22'($urandom) & 22'h3F003C;
      rb  = 22'($urandom) & 22'h3F003C;
      rwm = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      model_step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), rb, rwm, $urandom);
    end
    // Drain the last pending read
    model_step(0, 22'h0, 0, 22'h0, 4'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
